// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue/stall controller between the EX stage and the multi
// multiply/divide unit. It accepts MD-class instructions, registers their
// operands, pulses mul_start for one cycle and holds EX while the unit is busy.
// MFHI/MFLO data is returned combinationally when the unit is idle.
// Optional build macro: MD_PERF_CNT_EN adds a saturating 32-bit stall-cycle
// counter on perf_stall; without it perf_stall is tied to zero.
module md_issue_ctrl #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              md_valid,
   input  logic [OP_W-1:0]   md_op,
   input  logic [DATA_W-1:0] rs_val,
   input  logic [DATA_W-1:0] rt_val,
   input  logic              flush,
   output logic              stall,
   output logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] mul_A,
   output logic [DATA_W-1:0] mul_B,
   output logic [OP_W-1:0]   mul_op,
   output logic              mul_start,
   input  logic              mul_busy,
   input  logic [DATA_W-1:0] mul_hi,
   input  logic [DATA_W-1:0] mul_lo,
   output logic [31:0]       perf_stall
);

   // MD opcode encoding
   localparam logic [OP_W-1:0] OP_MULT = OP_W'(1);
   localparam logic [OP_W-1:0] OP_MTLO = OP_W'(6);
   localparam logic [OP_W-1:0] OP_MFHI = OP_W'(7);
   localparam logic [OP_W-1:0] OP_MFLO = OP_W'(8);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t state;
   state_t next_state;

   logic is_issue;
   logic is_read;
   logic accept;
   logic load_ops;

   // Decode the opcode into issue-class (unit operations) and read-class (MFHI/MFLO)
   always_comb begin
      is_issue = (md_op >= OP_MULT) && (md_op <= OP_MTLO);
      is_read  = (md_op == OP_MFHI) || (md_op == OP_MFLO);
      accept   = md_valid && !flush && is_issue && (state == S_IDLE);
   end

   // State register; reset drops any in-flight operation since multi resets too
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: ARM lasts exactly one cycle, WAIT exits on the first idle busy
   always_comb begin
      next_state = state;
      load_ops   = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               next_state = S_ARM;
               load_ops   = 1'b1;
            end
         end
         S_ARM: begin
            next_state = S_WAIT;
         end
         S_WAIT: begin
            if (!mul_busy) begin
               next_state = S_IDLE;
            end
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Operand/opcode registers for multi, captured only on accept so flushed ops leave them alone
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mul_A  <= '0;
         mul_B  <= '0;
         mul_op <= '0;
      end else if (load_ops) begin
         mul_A  <= rs_val;
         mul_B  <= rt_val;
         mul_op <= md_op;
      end
   end

   // Start pulse is registered so it is high exactly during the ARM cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mul_start <= 1'b0;
      end else begin
         mul_start <= load_ops;
      end
   end

   // Stall any MD instruction while the unit is occupied; an accepted op never stalls itself
   always_comb begin
      stall = md_valid && (is_issue || is_read) && (state != S_IDLE);
   end

   // MFHI/MFLO return HI/LO in the same cycle, only when not stalled
   always_comb begin
      rd_data = '0;
      if (md_valid && (state == S_IDLE)) begin
         if (md_op == OP_MFHI) begin
            rd_data = mul_hi;
         end else if (md_op == OP_MFLO) begin
            rd_data = mul_lo;
         end
      end
   end

`ifdef MD_PERF_CNT_EN
   logic [31:0] stall_cnt;

   // Saturating count of stalled cycles
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= 32'd0;
      end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign perf_stall = stall_cnt;
`else
   assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: directed test of md_issue_ctrl with the multi unit's busy
// and HI/LO driven by hand-written steps. Honours MD_PERF_CNT_EN.
module tb_md_issue_ctrl;

   logic        clk;
   logic        reset;
   logic        md_valid;
   logic [3:0]  md_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        flush;
   logic        stall;
   logic [31:0] rd_data;
   logic [31:0] mul_A;
   logic [31:0] mul_B;
   logic [3:0]  mul_op;
   logic        mul_start;
   logic        mul_busy;
   logic [31:0] mul_hi;
   logic [31:0] mul_lo;
   logic [31:0] perf_stall;

   int total;
   int bad;
   int exp_perf;

   md_issue_ctrl #(.DATA_W(32), .OP_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .md_valid   (md_valid),
      .md_op      (md_op),
      .rs_val     (rs_val),
      .rt_val     (rt_val),
      .flush      (flush),
      .stall      (stall),
      .rd_data    (rd_data),
      .mul_A      (mul_A),
      .mul_B      (mul_B),
      .mul_op     (mul_op),
      .mul_start  (mul_start),
      .mul_busy   (mul_busy),
      .mul_hi     (mul_hi),
      .mul_lo     (mul_lo),
      .perf_stall (perf_stall)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One cycle: drive inputs at the falling edge, settle, then let checks sample
   task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic fl, input logic busy);
      @(negedge clk);
      md_valid = v;
      md_op    = op;
      rs_val   = a;
      rt_val   = b;
      flush    = fl;
      mul_busy = busy;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected perf counter value depends on the build
   function automatic logic [31:0] perfExp(input int n);
`ifdef MD_PERF_CNT_EN
      return 32'(n);
`else
      return 32'd0;
`endif
   endfunction

   initial begin
      total    = 0;
      bad      = 0;
      exp_perf = 0;
      reset    = 1'b0;
      md_valid = 1'b0;
      md_op    = 4'd0;
      rs_val   = 32'd0;
      rt_val   = 32'd0;
      flush    = 1'b0;
      mul_busy = 1'b0;
      mul_hi   = 32'd0;
      mul_lo   = 32'd0;

      // Reset state
      #3;
      checkOutput("rst_stall", 32'(stall), 32'd0);
      checkOutput("rst_start", 32'(mul_start), 32'd0);
      checkOutput("rst_A", mul_A, 32'd0);
      checkOutput("rst_B", mul_B, 32'd0);
      checkOutput("rst_op", 32'(mul_op), 32'd0);
      checkOutput("rst_perf", perf_stall, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // MULT 5x3
      applyStimulus(1'b1, 4'd1, 32'd5, 32'd3, 1'b0, 1'b0);
      checkOutput("mult_issue_stall", 32'(stall), 32'd0);
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("mult_start", 32'(mul_start), 32'd1);
      checkOutput("mult_A", mul_A, 32'd5);
      checkOutput("mult_B", mul_B, 32'd3);
      checkOutput("mult_op", 32'(mul_op), 32'd1);
      applyStimulus(1'b1, 4'd7, 32'd0, 32'd0, 1'b0, 1'b1);
      checkOutput("mult_start_drop", 32'(mul_start), 32'd0);
      checkOutput("mult_wait_stall1", 32'(stall), 32'd1);
      exp_perf++;
      applyStimulus(1'b1, 4'd7, 32'd0, 32'd0, 1'b0, 1'b1);
      checkOutput("mult_wait_stall2", 32'(stall), 32'd1);
      exp_perf++;
      mul_lo = 32'd15;
      applyStimulus(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("mult_busy_drop_stall", 32'(stall), 32'd1);
      checkOutput("mult_stalled_rd", rd_data, 32'd0);
      exp_perf++;
      applyStimulus(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("mult_idle_stall", 32'(stall), 32'd0);
      checkOutput("mult_mflo", rd_data, 32'd15);
      checkOutput("mult_perf", perf_stall, perfExp(exp_perf));

      // DIV 100/7 followed by MFLO held off by 10 busy cycles
      applyStimulus(1'b1, 4'd3, 32'd100, 32'd7, 1'b0, 1'b0);
      checkOutput("div_issue_stall", 32'(stall), 32'd0);
      applyStimulus(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("div_arm_stall", 32'(stall), 32'd1);
      checkOutput("div_start", 32'(mul_start), 32'd1);
      checkOutput("div_A", mul_A, 32'd100);
      checkOutput("div_B", mul_B, 32'd7);
      checkOutput("div_op", 32'(mul_op), 32'd3);
      exp_perf++;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b1);
         checkOutput($sformatf("div_busy_stall%0d", i), 32'(stall), 32'd1);
         exp_perf++;
      end
      applyStimulus(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("div_last_stall", 32'(stall), 32'd1);
      exp_perf++;
      mul_hi = 32'd2;
      mul_lo = 32'd14;
      applyStimulus(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("div_mflo_stall", 32'(stall), 32'd0);
      checkOutput("div_mflo_data", rd_data, 32'd14);
      checkOutput("div_perf", perf_stall, perfExp(exp_perf));

      // Flush on the accept cycle: MULTU must not issue
      applyStimulus(1'b1, 4'd2, 32'd9, 32'd9, 1'b1, 1'b0);
      checkOutput("flush_acc_stall", 32'(stall), 32'd0);
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("flush_acc_start", 32'(mul_start), 32'd0);
      checkOutput("flush_acc_A", mul_A, 32'd100);
      applyStimulus(1'b1, 4'd7, 32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("flush_acc_idle", 32'(stall), 32'd0);
      checkOutput("flush_acc_mfhi", rd_data, 32'd2);

      // Flush while the unit is working has no effect
      applyStimulus(1'b1, 4'd2, 32'd6, 32'd7, 1'b0, 1'b0);
      checkOutput("fw_issue_stall", 32'(stall), 32'd0);
      applyStimulus(1'b1, 4'd2, 32'd6, 32'd7, 1'b1, 1'b0);
      checkOutput("fw_arm_stall", 32'(stall), 32'd1);
      checkOutput("fw_start", 32'(mul_start), 32'd1);
      checkOutput("fw_A", mul_A, 32'd6);
      checkOutput("fw_op", 32'(mul_op), 32'd2);
      exp_perf++;
      applyStimulus(1'b1, 4'd2, 32'd6, 32'd7, 1'b1, 1'b1);
      checkOutput("fw_wait_stall1", 32'(stall), 32'd1);
      checkOutput("fw_start_drop", 32'(mul_start), 32'd0);
      exp_perf++;
      applyStimulus(1'b1, 4'd2, 32'd6, 32'd7, 1'b1, 1'b1);
      checkOutput("fw_wait_stall2", 32'(stall), 32'd1);
      exp_perf++;
      applyStimulus(1'b1, 4'd2, 32'd6, 32'd7, 1'b1, 1'b0);
      checkOutput("fw_wait_stall3", 32'(stall), 32'd1);
      exp_perf++;
      applyStimulus(1'b1, 4'd7, 32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("fw_idle", 32'(stall), 32'd0);
      checkOutput("fw_perf", perf_stall, perfExp(exp_perf));

      // NOP opcode is ignored
      applyStimulus(1'b1, 4'd9, 32'd1, 32'd1, 1'b0, 1'b0);
      checkOutput("nop_stall", 32'(stall), 32'd0);
      checkOutput("nop_rd", rd_data, 32'd0);
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("nop_start", 32'(mul_start), 32'd0);

      // Asynchronous reset in the middle of WAIT
      applyStimulus(1'b1, 4'd1, 32'd1, 32'd1, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("ar_start", 32'(mul_start), 32'd1);
      applyStimulus(1'b1, 4'd7, 32'd0, 32'd0, 1'b0, 1'b1);
      checkOutput("ar_wait_stall", 32'(stall), 32'd1);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("ar_rst_start", 32'(mul_start), 32'd0);
      checkOutput("ar_rst_stall", 32'(stall), 32'd0);
      checkOutput("ar_rst_A", mul_A, 32'd0);
      checkOutput("ar_rst_perf", perf_stall, 32'd0);
      exp_perf = 0;
      #1;
      reset    = 1'b1;
      mul_busy = 1'b0;
      applyStimulus(1'b1, 4'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
      checkOutput("mthi_issue_stall", 32'(stall), 32'd0);
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("mthi_start", 32'(mul_start), 32'd1);
      checkOutput("mthi_A", mul_A, 32'hDEAD_BEEF);
      checkOutput("mthi_op", 32'(mul_op), 32'd5);
      applyStimulus(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("mthi_wait_stall", 32'(stall), 32'd1);
      exp_perf++;
      applyStimulus(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("mthi_idle", 32'(stall), 32'd0);
      checkOutput("mthi_perf", perf_stall, perfExp(exp_perf));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
